// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline and load-return writeback ports share
// one register-file write port, with starvation relief for the load path.
// An optional load scoreboard is built when REGFILE_SCOREBOARD_EN is defined.
// The scoreboard tracks pending load destinations and flags decode hazards.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_wb_valid_i,
   input  logic [4:0]  pipe_wb_addr_i,
   input  logic [31:0] pipe_wb_data_i,
   output logic        pipe_wb_ready_o,
   input  logic        load_wb_valid_i,
   input  logic [4:0]  load_wb_addr_i,
   input  logic [31:0] load_wb_data_i,
   output logic        load_wb_ready_o,
   input  logic        load_issue_i,
   input  logic [4:0]  load_issue_addr_i,
   output logic        load_issue_ready_o,
   input  logic [4:0]  read_addr_1_i,
   input  logic [4:0]  read_addr_2_i,
   output logic        hazard_1_o,
   output logic        hazard_2_o,
   output logic        write_en_o,
   output logic [4:0]  write_addr_o,
   output logic [31:0] write_data_o,
   output logic        pipe_stall_o
);

   localparam int unsigned AW   = 5;
   localparam int unsigned DW   = 32;
   localparam int unsigned CW   = 4;
   localparam int unsigned NREG = 32;

   logic [CW-1:0] starve_cnt;
   logic [CW-1:0] starve_nxt;
   logic          load_win;
   logic          pipe_win;
   logic          grant;
   logic [AW-1:0] grant_addr;
   logic [DW-1:0] grant_data;

   // Arbitration: pipeline has priority unless the load path has lost STARVE_LIMIT times in a row.
   // Every grant is masked while rst is low so nothing is granted during reset.
   always_comb begin
      load_win   = 1'b0;
      pipe_win   = 1'b0;
      grant_addr = pipe_wb_addr_i;
      grant_data = pipe_wb_data_i;
      starve_nxt = '0;
      load_win   = rst & load_wb_valid_i &
                   (~pipe_wb_valid_i | (starve_cnt == CW'(STARVE_LIMIT)));
      pipe_win   = rst & pipe_wb_valid_i & ~load_win;
      if (load_win) begin
         grant_addr = load_wb_addr_i;
         grant_data = load_wb_data_i;
      end
      if (load_wb_valid_i && !load_win) begin
         starve_nxt = starve_cnt + CW'(1);
      end
   end

   assign grant           = pipe_win | load_win;
   assign pipe_wb_ready_o = pipe_win;
   assign load_wb_ready_o = load_win;
   assign pipe_stall_o    = rst & pipe_wb_valid_i & ~pipe_win;

   // Starvation counter: counts consecutive cycles in which a valid load lost arbitration.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_nxt;
      end
   end

   // Write-port register: r0 grants are consumed without a write; address and data hold when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         write_en_o   <= 1'b0;
         write_addr_o <= '0;
         write_data_o <= '0;
      end else if (grant && (grant_addr != '0)) begin
         write_en_o   <= 1'b1;
         write_addr_o <= grant_addr;
         write_data_o <= grant_data;
      end else begin
         write_en_o   <= 1'b0;
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;
   logic            issue_ok;

   assign issue_ok           = rst & ~pending[load_issue_addr_i];
   assign load_issue_ready_o = issue_ok;
   assign hazard_1_o         = rst & pending[read_addr_1_i];
   assign hazard_2_o         = rst & pending[read_addr_2_i];

   // Next pending vector: the load grant clears its bit, an accepted issue sets its bit.
   // The set is applied last, so it wins when both target the same register; r0 never pends.
   always_comb begin
      pending_nxt = pending;
      if (load_win) begin
         pending_nxt[load_wb_addr_i] = 1'b0;
      end
      if (load_issue_i && issue_ok) begin
         pending_nxt[load_issue_addr_i] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   // Pending-load vector register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end
`else
   logic unused_sb_inputs;

   assign load_issue_ready_o = rst;
   assign hazard_1_o         = 1'b0;
   assign hazard_2_o         = 1'b0;
   assign unused_sb_inputs   = ^{load_issue_i, load_issue_addr_i, read_addr_1_i, read_addr_2_i};
`endif

endmodule
